// File: rtl/reduce_ctrl.sv
// reduce_ctrl
// Sequencing controller that reduces a burst of 4-bit unsigned operands to
// one 8-bit result (min, max, sum or range) and holds it on a high/low
// nibble pair until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      job request, sampled only in IDLE
//   op         reduction select latched on start: 00 min, 01 max, 10 sum, 11 range
//   in_data    operand (unsigned)
//   in_valid   operand valid
//   in_last    final operand marker, qualified by in_valid
//   in_ready   operand accepted this cycle when in_valid is also high
//   res_high   result bits [7:4]
//   res_low    result bits [3:0]
//   res_valid  result available
//   res_ready  consumer accepts the result
//   busy       job in progress (ACC or DONE)
//   trunc      burst ended by the MAX_LEN limit rather than in_last
module reduce_ctrl #(
    parameter int MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] res_high,
    output logic [3:0] res_low,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       trunc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_MIN   = 2'b00;
    localparam logic [1:0] OP_MAX   = 2'b01;
    localparam logic [1:0] OP_SUM   = 2'b10;
    localparam logic [1:0] OP_RANGE = 2'b11;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

    state_t     state;
    logic [1:0] op_q;
    logic [3:0] count;
    logic [3:0] cur_min;
    logic [3:0] cur_max;
    logic [7:0] sum;

    logic       accept;
    logic       first;
    logic [3:0] nxt_min;
    logic [3:0] nxt_max;
    logic [7:0] nxt_sum;
    logic [3:0] nxt_count;
    logic       burst_end;
    logic [7:0] result;

    // Running-reduction next values; the first operand of a burst reloads
    // every accumulator so nothing from an earlier job can leak in.
    always_comb begin
        accept    = in_valid && in_ready;
        first     = (count == 4'd0);
        nxt_count = count + 4'd1;
        if (first) begin
            nxt_min = in_data;
            nxt_max = in_data;
            nxt_sum = {4'd0, in_data};
        end else begin
            nxt_min = (in_data < cur_min) ? in_data : cur_min;
            nxt_max = (in_data > cur_max) ? in_data : cur_max;
            nxt_sum = sum + {4'd0, in_data};
        end
        burst_end = in_last || (nxt_count == MAX_CNT);
    end

    // Result selection from the post-update values so the result register
    // is loaded on the same edge that accepts the final operand.
    always_comb begin
        case (op_q)
            OP_MIN:   result = {4'd0, nxt_min};
            OP_MAX:   result = {4'd0, nxt_max};
            OP_SUM:   result = nxt_sum;
            OP_RANGE: result = {4'd0, nxt_max - nxt_min};
            default:  result = 8'd0;
        endcase
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            count     <= 4'd0;
            cur_min   <= 4'd0;
            cur_max   <= 4'd0;
            sum       <= 8'd0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            trunc     <= 1'b0;
            res_high  <= 4'd0;
            res_low   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        count    <= 4'd0;
                        trunc    <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC: begin
                    if (accept) begin
                        cur_min <= nxt_min;
                        cur_max <= nxt_max;
                        sum     <= nxt_sum;
                        count   <= nxt_count;
                        if (burst_end) begin
                            // in_last wins when it coincides with the limit.
                            trunc     <= !in_last;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                            res_high  <= result[7:4];
                            res_low   <= result[3:0];
                            state     <= DONE;
                        end else begin
                            state <= ACC;
                        end
                    end else begin
                        state <= ACC;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_ctrl.sv
// Directed self-checking bench for reduce_ctrl.
module tb_reduce_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [3:0] res_high;
    logic [3:0] res_low;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       trunc;

    int compared   = 0;
    int mismatched = 0;

    reduce_ctrl #(.MAX_LEN(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_high  (res_high),
        .res_low   (res_low),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .trunc     (trunc)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand for exactly one edge (caller ensures ACC).
    task automatic send(input logic [3:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] o);
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        in_data   = 4'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        #2;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",  {7'd0, in_ready},  8'd0);
        chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
        chk("rst_busy",      {7'd0, busy},      8'd0);
        chk("rst_trunc",     {7'd0, trunc},     8'd0);
        chk("rst_result",    {res_high, res_low}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Min burst 9,3,7,5
        res_ready = 1'b1;
        do_start(2'b00);
        chk("min_in_ready", {7'd0, in_ready}, 8'd1);
        chk("min_busy",     {7'd0, busy},     8'd1);
        send(4'd9, 1'b0);
        send(4'd3, 1'b0);
        send(4'd7, 1'b0);
        send(4'd5, 1'b1);
        chk("min_res_valid", {7'd0, res_valid}, 8'd1);
        chk("min_result",    {res_high, res_low}, 8'h03);
        chk("min_trunc",     {7'd0, trunc},     8'd0);
        chk("min_in_ready0", {7'd0, in_ready},  8'd0);
        tick();
        chk("min_idle_valid", {7'd0, res_valid}, 8'd0);
        chk("min_idle_busy",  {7'd0, busy},      8'd0);

        // Sum with truncation: fifteen 0xF, no in_last
        res_ready = 1'b0;
        do_start(2'b10);
        in_data  = 4'hF;
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sum_ready_at14", {7'd0, in_ready}, 8'd1);
        chk("sum_valid_at14", {7'd0, res_valid}, 8'd0);
        tick();
        chk("sum_ready_drop", {7'd0, in_ready}, 8'd0);
        chk("sum_res_valid",  {7'd0, res_valid}, 8'd1);
        chk("sum_result",     {res_high, res_low}, 8'hE1);
        chk("sum_trunc",      {7'd0, trunc}, 8'd1);
        // 16th operand held valid must not alter anything
        tick();
        chk("sum_16th_result", {res_high, res_low}, 8'hE1);
        chk("sum_16th_valid",  {7'd0, res_valid}, 8'd1);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("sum_idle", {7'd0, busy}, 8'd0);

        // Range 4,12,4
        do_start(2'b11);
        send(4'd4,  1'b0);
        send(4'd12, 1'b0);
        send(4'd4,  1'b1);
        chk("range_result", {res_high, res_low}, 8'h08);
        chk("range_trunc",  {7'd0, trunc}, 8'd0);
        tick();

        // Range single operand
        do_start(2'b11);
        send(4'd6, 1'b1);
        chk("range1_valid",  {7'd0, res_valid}, 8'd1);
        chk("range1_result", {res_high, res_low}, 8'h00);
        tick();

        // Backpressure on max 2,14,7 with a start pulse during the hold
        res_ready = 1'b0;
        do_start(2'b01);
        op = 2'b00;  // mid-burst op change must have no effect
        send(4'd2,  1'b0);
        send(4'd14, 1'b0);
        send(4'd7,  1'b1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            chk("bp_valid",  {7'd0, res_valid}, 8'd1);
            chk("bp_result", {res_high, res_low}, 8'h0E);
            tick();
        end
        start = 1'b0;
        chk("bp_still_valid", {7'd0, res_valid}, 8'd1);
        res_ready = 1'b1;
        tick();
        chk("bp_accept_valid", {7'd0, res_valid}, 8'd0);
        chk("bp_accept_busy",  {7'd0, busy}, 8'd0);
        chk("bp_hold_after",   {res_high, res_low}, 8'h0E);
        tick();
        chk("bp_no_restart", {7'd0, busy}, 8'd0);

        // in_valid in IDLE is ignored; gaps inside ACC are not counted
        in_data  = 4'hF;
        in_valid = 1'b1;
        tick();
        tick();
        chk("idle_in_ready", {7'd0, in_ready}, 8'd0);
        chk("idle_busy",     {7'd0, busy}, 8'd0);
        in_valid = 1'b0;
        do_start(2'b10);
        send(4'd5, 1'b0);
        in_data = 4'd9;
        tick();
        tick();
        send(4'd3, 1'b1);
        chk("gap_result", {res_high, res_low}, 8'h08);
        chk("gap_trunc",  {7'd0, trunc}, 8'd0);
        tick();

        // Reset mid-burst, then a fresh job
        do_start(2'b00);
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mrst_in_ready",  {7'd0, in_ready},  8'd0);
        chk("mrst_res_valid", {7'd0, res_valid}, 8'd0);
        chk("mrst_busy",      {7'd0, busy},      8'd0);
        chk("mrst_trunc",     {7'd0, trunc},     8'd0);
        chk("mrst_result",    {res_high, res_low}, 8'h00);
        rst_n = 1'b1;
        tick();
        do_start(2'b00);
        send(4'd8, 1'b0);
        send(4'd9, 1'b1);
        chk("fresh_min", {res_high, res_low}, 8'h08);
        tick();
        do_start(2'b10);
        send(4'd7, 1'b0);
        send(4'd9, 1'b1);
        chk("fresh_sum", {res_high, res_low}, 8'h10);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
